// File: rtl/shift_register_32bit_ctrl.sv
// shift_register_32bit_ctrl: serialises a request word MSB-first into a 3-stage shift register,
// flushes it through to DATA_OUT and returns the captured word on a valid/ready response port.
module shift_register_32bit_ctrl #(
    parameter int WIDTH = 32,
    parameter int FLUSH = 2,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    input  logic             abort,
    output logic             shift_en,
    output logic             sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             busy
);
    localparam int PW = $clog2(WIDTH + FLUSH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [PW-1:0] LAST     = PW'(WIDTH + FLUSH - 1);
    localparam logic [PW-1:0] W_P      = PW'(WIDTH);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_FLUSH, S_CAPTURE, S_RESP} state_t;
    state_t           state, state_nxt;
    logic [PW-1:0]    pcnt, pcnt_nxt, pnext;
    logic [GW-1:0]    gcnt, gcnt_nxt;
    logic [WIDTH-1:0] sbuf, sbuf_nxt, res_data_nxt;
    logic             req_ready_nxt, res_valid_nxt, shift_en_nxt, sr_data_in_nxt;
    assign pnext = pcnt + 1'b1;
    assign busy  = state != S_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pcnt       <= '0;
            gcnt       <= '0;
            sbuf       <= '0;
            req_ready  <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            shift_en   <= 1'b0;
            sr_data_in <= 1'b0;
        end else begin
            state      <= state_nxt;
            pcnt       <= pcnt_nxt;
            gcnt       <= gcnt_nxt;
            sbuf       <= sbuf_nxt;
            req_ready  <= req_ready_nxt;
            res_valid  <= res_valid_nxt;
            res_data   <= res_data_nxt;
            shift_en   <= shift_en_nxt;
            sr_data_in <= sr_data_in_nxt;
        end
    end
    // The buffer shifts left on every pulse, so once the word is out it feeds zeros for the flush.
    always_comb begin
        state_nxt      = state;
        pcnt_nxt       = pcnt;
        gcnt_nxt       = gcnt;
        sbuf_nxt       = sbuf;
        res_valid_nxt  = res_valid;
        res_data_nxt   = res_data;
        shift_en_nxt   = 1'b0;
        sr_data_in_nxt = sr_data_in;
        case (state)
            S_IDLE: if (req_valid && req_ready) begin
                sbuf_nxt       = req_data << 1;
                sr_data_in_nxt = req_data[WIDTH-1];
                shift_en_nxt   = 1'b1;
                pcnt_nxt       = '0;
                gcnt_nxt       = '0;
                state_nxt      = S_SHIFT;
            end
            S_SHIFT, S_FLUSH: begin
                if (shift_en && pcnt == LAST) begin
                    pcnt_nxt  = '0;
                    state_nxt = S_CAPTURE;
                end else if (shift_en ? GAP == 0 : gcnt == GAP_LAST) begin
                    sbuf_nxt       = sbuf << 1;
                    sr_data_in_nxt = sbuf[WIDTH-1];
                    shift_en_nxt   = 1'b1;
                    pcnt_nxt       = pnext;
                    gcnt_nxt       = '0;
                    state_nxt      = (pnext < W_P) ? S_SHIFT : S_FLUSH;
                end else if (!shift_en) begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                res_data_nxt  = sr_data_out;
                res_valid_nxt = 1'b1;
                state_nxt     = S_RESP;
            end
            S_RESP: if (res_valid && res_ready) begin
                res_valid_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt     = S_IDLE;
            shift_en_nxt  = 1'b0;
            res_valid_nxt = 1'b0;
            res_data_nxt  = res_data;
            pcnt_nxt      = '0;
            gcnt_nxt      = '0;
        end
        req_ready_nxt = state_nxt == S_IDLE;
    end
endmodule

// File: tb/tb_shift_register_32bit_ctrl.sv
// tb_shift_register_32bit_ctrl: two controllers (GAP=0 and GAP=3), each driving its own 3-stage register model.
module tb_shift_register_32bit_ctrl;
    localparam int W = 32, FL = 2, N = W + FL;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req_valid, req_ready, res_valid, res_ready, abort, shift_en, sr_in, busy;
    logic [1:0][W-1:0] req_data, res_data, sr_out;
    int cyc = 0, vec = 0, errs = 0, mon = 0, last_hs = 0;
    int pcyc[$];
    bit pbit[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (shift_en[mon]) begin
        pcyc.push_back(cyc);
        pbit.push_back(sr_in[mon]);
    end

    for (genvar g = 0; g < 2; g++) begin : lane
        logic [W-1:0] s0 = '0, s1 = '0, s2 = '0;
        always @(posedge clk) if (shift_en[g]) begin
            s0 <= {s0[W-2:0], sr_in[g]};
            s1 <= s0;
            s2 <= s1;
        end
        assign sr_out[g] = s2;
        shift_register_32bit_ctrl #(.WIDTH(W), .FLUSH(FL), .GAP(3 * g)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_data(req_data[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready[g]), .res_data(res_data[g]),
            .abort(abort[g]), .shift_en(shift_en[g]), .sr_data_in(sr_in[g]),
            .sr_data_out(sr_out[g]), .busy(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int l, input logic [W-1:0] w, input bit ab, output int acc);
        int t = 0;
        while (!req_ready[l] && t < 100) begin @(negedge clk); t++; end
        chk("accept_ready", req_ready[l], 1);
        pcyc.delete();
        pbit.delete();
        mon = l;
        req_data[l] = w;
        req_valid[l] = 1'b1;
        abort[l] = ab;
        @(negedge clk);
        req_valid[l] = 1'b0;
        abort[l] = 1'b0;
        acc = cyc;
        chk("accept_busy", {busy[l], req_ready[l]}, 2'b10);
    endtask

    task automatic complete(input int l, input logic [W-1:0] w, input int gap, input int acc, input int hold);
        int t = 0, bad = 0;
        while (!res_valid[l] && t < 400) begin @(negedge clk); t++; end
        chk("latency", cyc - acc, (N - 1) * (gap + 1) + 2);
        chk("res_data", res_data[l], w);
        chk("pulse_count", pcyc.size(), N);
        foreach (pcyc[i])
            if (pcyc[i] != acc + i * (gap + 1) || pbit[i] != ((i < W) ? w[W-1-i] : 1'b0)) bad++;
        chk("pulse_seq", bad, 0);
        for (int i = 0; i < hold; i++) begin
            req_valid[l] = i[0];
            req_data[l] = $urandom;
            @(negedge clk);
            if (!res_valid[l] || res_data[l] !== w || req_ready[l]) bad++;
        end
        req_valid[l] = 1'b0;
        if (hold > 0) chk("hold_stable", bad, 0);
        res_ready[l] = 1'b1;
        @(negedge clk);
        res_ready[l] = 1'b0;
        last_hs = cyc;
        chk("resp_done", {res_valid[l], busy[l], req_ready[l]}, 3'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, bad;
        logic [W-1:0] w;
        logic [W-1:0] stream [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE};
        req_valid = '0; res_ready = '0; abort = '0; req_data = '0;
        #1;
        chk("rst_outputs", {req_ready[0], res_valid[0], shift_en[0], sr_in[0], busy[0]}, 5'b0);
        chk("rst_res_data", res_data[0], 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 2'b11);
        // single word with back-pressure and ignored requests while responding
        accept(0, 32'hA5C3_0F81, 1'b0, acc);
        complete(0, 32'hA5C3_0F81, 0, acc, 10);
        // spaced pulses
        accept(1, 32'hFFFF_0000, 1'b0, acc);
        complete(1, 32'hFFFF_0000, 3, acc, 0);
        // abort while idle must not block the request
        w = $urandom;
        accept(1, w, 1'b1, acc);
        complete(1, w, 3, acc, 2);
        // abort mid-shift
        accept(0, $urandom, 1'b0, acc);
        repeat (10) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_state", {shift_en[0], busy[0], res_valid[0], req_ready[0]}, 4'b0001);
        bad = 0;
        repeat (40) begin @(negedge clk); if (res_valid[0] || shift_en[0]) bad++; end
        chk("abort_quiet", bad, 0);
        accept(0, 32'h0000_0001, 1'b0, acc);
        complete(0, 32'h0000_0001, 0, acc, 0);
        // asynchronous reset during flush
        accept(0, $urandom, 1'b0, acc);
        repeat (32) @(negedge clk);
        chk("in_flush", {shift_en[0], busy[0]}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_flush", {shift_en[0], res_valid[0], busy[0], req_ready[0]}, 4'b0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(0, 32'h1234_5678, 1'b0, acc);
        complete(0, 32'h1234_5678, 0, acc, 0);
        // back-to-back streaming
        for (int i = 0; i < 4; i++) begin
            accept(0, stream[i], 1'b0, acc);
            if (i > 0) chk("turnaround", acc - last_hs, 1);
            complete(0, stream[i], 0, acc, 0);
        end
        // random words on both lanes with random back-pressure
        for (int i = 0; i < 6; i++) begin
            int l = (i % 3 == 2) ? 1 : 0;
            w = $urandom;
            accept(l, w, 1'b0, acc);
            complete(l, w, 3 * l, acc, $urandom_range(0, 3));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
